// File: rtl/reg_dump_unit.sv
// Streams every register of a bank to a byte-wide transmitter, least-significant byte first.
// Register reads wait one extra cycle because the bank read is registered.
module reg_dump_unit #(
  parameter int NB_DATA    = 32,
  parameter int NB_ADDR    = 5,
  parameter int BANK_DEPTH = 32,
  parameter int NB_BYTE    = 8
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic               i_start,
  output logic [NB_ADDR-1:0] o_rd_addr,
  input  logic [NB_DATA-1:0] i_rd_data,
  output logic [NB_BYTE-1:0] o_tx_data,
  output logic               o_tx_start,
  input  logic               i_tx_done,
  output logic               o_busy,
  output logic               o_done
);

  localparam int BYTES_PER_REG = NB_DATA / NB_BYTE;
  localparam int NB_BIDX       = (BYTES_PER_REG > 1) ? $clog2(BYTES_PER_REG) : 1;
  localparam logic [NB_BIDX-1:0] LAST_BYTE = NB_BIDX'(BYTES_PER_REG - 1);
  localparam logic [NB_ADDR-1:0] LAST_REG  = NB_ADDR'(BANK_DEPTH - 1);

  typedef enum logic [2:0] {IDLE, ADDR, LATCH, SEND, WAIT_TX, DONE} state_t;

  state_t             state_reg, state_next;
  logic [NB_ADDR-1:0] reg_idx_reg, reg_idx_next;
  logic [NB_BIDX-1:0] byte_idx_reg, byte_idx_next;
  logic [NB_DATA-1:0] shift_reg, shift_next;
  logic [NB_BYTE-1:0] tx_data_reg, tx_data_next;
  logic [NB_DATA-1:0] shifted;

  assign shifted   = shift_reg >> NB_BYTE;
  assign o_tx_data = tx_data_reg;

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_reg    <= IDLE;
      reg_idx_reg  <= '0;
      byte_idx_reg <= '0;
      shift_reg    <= '0;
      tx_data_reg  <= '0;
    end else begin
      state_reg    <= state_next;
      reg_idx_reg  <= reg_idx_next;
      byte_idx_reg <= byte_idx_next;
      shift_reg    <= shift_next;
      tx_data_reg  <= tx_data_next;
    end
  end

  // tx_data_reg is loaded together with the shift register so the byte is
  // already on o_tx_data in the SEND cycle and then holds until the next SEND.
  always_comb begin
    state_next    = state_reg;
    reg_idx_next  = reg_idx_reg;
    byte_idx_next = byte_idx_reg;
    shift_next    = shift_reg;
    tx_data_next  = tx_data_reg;
    o_rd_addr     = reg_idx_reg;
    o_tx_start    = 1'b0;
    o_busy        = 1'b1;
    o_done        = 1'b0;

    case (state_reg)
      IDLE: begin
        o_busy    = 1'b0;
        o_rd_addr = '0;
        if (i_start) begin
          reg_idx_next  = '0;
          byte_idx_next = '0;
          state_next    = ADDR;
        end
      end
      ADDR: begin
        state_next = LATCH;
      end
      LATCH: begin
        shift_next   = i_rd_data;
        tx_data_next = i_rd_data[NB_BYTE-1:0];
        state_next   = SEND;
      end
      SEND: begin
        o_tx_start = 1'b1;
        state_next = WAIT_TX;
      end
      WAIT_TX: begin
        if (i_tx_done) begin
          if (byte_idx_reg != LAST_BYTE) begin
            byte_idx_next = byte_idx_reg + 1'b1;
            shift_next    = shifted;
            tx_data_next  = shifted[NB_BYTE-1:0];
            state_next    = SEND;
          end else if (reg_idx_reg != LAST_REG) begin
            byte_idx_next = '0;
            reg_idx_next  = reg_idx_reg + 1'b1;
            state_next    = ADDR;
          end else begin
            state_next = DONE;
          end
        end
      end
      DONE: begin
        o_done     = 1'b1;
        o_rd_addr  = '0;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_reg_dump_unit.sv
// Directed bench for reg_dump_unit: registered-read bank model, transmitter responder
// with programmable done latency, and a stream monitor feeding per-scenario tasks.
module tb_reg_dump_unit;
  localparam int NB_DATA    = 32;
  localparam int NB_ADDR    = 5;
  localparam int BANK_DEPTH = 32;
  localparam int NB_BYTE    = 8;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               start = 1'b0;
  logic               tx_done = 1'b0;
  logic [NB_ADDR-1:0] rd_addr;
  logic [NB_DATA-1:0] rd_data = '0;
  logic [NB_BYTE-1:0] tx_data;
  logic               tx_start, busy, done;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [NB_DATA-1:0] bank [BANK_DEPTH];

  // responder controls
  int tx_delay = 5;
  bit spurious_en = 1'b0;
  int cnt = 0;
  int acked = 0;
  bit addr_next = 1'b0;

  // monitor state
  logic [NB_BYTE-1:0] bytes_q [$];
  logic [NB_ADDR-1:0] addr_q [$];
  int starts_q [$];
  int done_count = 0;
  int done_cyc = -1;
  int busy_fall_cyc = -1;
  logic busy_prev = 1'b0;
  int clear_gen = 0;
  int seen_gen = 0;
  int start_cyc = 0;

  reg_dump_unit #(
    .NB_DATA(NB_DATA), .NB_ADDR(NB_ADDR), .BANK_DEPTH(BANK_DEPTH), .NB_BYTE(NB_BYTE)
  ) dut (
    .i_clock(clk), .i_reset(rst), .i_start(start),
    .o_rd_addr(rd_addr), .i_rd_data(rd_data),
    .o_tx_data(tx_data), .o_tx_start(tx_start), .i_tx_done(tx_done),
    .o_busy(busy), .o_done(done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) rd_data <= bank[rd_addr];

  // Transmitter: done pulse tx_delay cycles after each start; optional spurious
  // pulses in the SEND cycle and in the ADDR cycle after each register.
  always @(negedge clk) begin
    tx_done = 1'b0;
    if (start) acked = 0;
    if (rst) begin
      cnt = 0;
      addr_next = 1'b0;
    end else begin
      if (addr_next) begin
        tx_done = 1'b1;
        addr_next = 1'b0;
      end
      if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin
          tx_done = 1'b1;
          acked++;
          if (spurious_en && (acked % 4 == 0)) addr_next = 1'b1;
        end
      end
      if (tx_start === 1'b1) begin
        cnt = tx_delay;
        if (spurious_en) tx_done = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    if (clear_gen != seen_gen) begin
      seen_gen = clear_gen;
      bytes_q.delete();
      addr_q.delete();
      starts_q.delete();
      done_count = 0;
      done_cyc = -1;
      busy_fall_cyc = -1;
    end
    if (tx_start === 1'b1) begin
      bytes_q.push_back(tx_data);
      addr_q.push_back(rd_addr);
      starts_q.push_back(cyc);
    end
    if (done === 1'b1) begin
      done_count++;
      done_cyc = cyc;
    end
    if (busy_prev === 1'b1 && busy === 1'b0) busy_fall_cyc = cyc;
    busy_prev = busy;
  end

  task automatic clear_mon();
    clear_gen++;
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    start_cyc = cyc;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_dump(input int budget, input string name);
    int n = 0;
    while (!(done_count > 0 && busy === 1'b0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    checks++;
    if (!(done_count > 0 && busy === 1'b0)) begin
      errors++;
      $display("FAIL %s_timeout: dump incomplete after %0d cycles, bytes=%0d required 128", name, budget, bytes_q.size());
    end
  endtask

  task automatic check_default_stream(input string name);
    checks++;
    if (bytes_q.size() !== 128) begin
      errors++;
      $display("FAIL %s_count: got %0d bytes, expected 128", name, bytes_q.size());
    end
    for (int i = 0; i < bytes_q.size() && i < 128; i++) begin
      checks++;
      if (bytes_q[i] !== 8'(i) || addr_q[i] !== 5'(i / 4)) begin
        errors++;
        $display("FAIL %s_byte%0d: got data 0x%02h addr %0d, expected data 0x%02h addr %0d",
                 name, i, bytes_q[i], addr_q[i], 8'(i), i / 4);
      end
    end
    checks++;
    if (done_count !== 1) begin
      errors++;
      $display("FAIL %s_done_count: got %0d, expected 1", name, done_count);
    end
    checks++;
    if (busy_fall_cyc !== done_cyc + 1) begin
      errors++;
      $display("FAIL %s_busy_fall: busy fell at %0d, expected %0d", name, busy_fall_cyc, done_cyc + 1);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({rd_addr, tx_data, tx_start, busy, done} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: addr=%0d data=0x%02h start=%b busy=%b done=%b, expected all 0",
               rd_addr, tx_data, tx_start, busy, done);
    end
    // i_start is ignored while reset is held
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_priority: busy=%b, expected 0", busy);
    end
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || tx_start !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle: busy=%b tx_start=%b, expected 0 0", busy, tx_start);
    end
  endtask

  task automatic test_full_dump();
    tx_delay = 5;
    clear_mon();
    pulse_start();
    wait_dump(3000, "full");
    check_default_stream("full");
  endtask

  task automatic test_deadbeef();
    logic [7:0] exp [4];
    exp[0] = 8'hEF; exp[1] = 8'hBE; exp[2] = 8'hAD; exp[3] = 8'hDE;
    bank[5] = 32'hDEADBEEF;
    tx_delay = 5;
    clear_mon();
    pulse_start();
    wait_dump(3000, "deadbeef");
    checks++;
    if (bytes_q.size() !== 128) begin
      errors++;
      $display("FAIL deadbeef_count: got %0d bytes, expected 128", bytes_q.size());
    end else begin
      for (int k = 0; k < 4; k++) begin
        checks++;
        if (bytes_q[20 + k] !== exp[k] || addr_q[20 + k] !== 5'd5) begin
          errors++;
          $display("FAIL deadbeef_byte%0d: got data 0x%02h addr %0d, expected data 0x%02h addr 5",
                   20 + k, bytes_q[20 + k], addr_q[20 + k], exp[k]);
        end
      end
    end
    bank[5] = 32'h17161514;
  endtask

  task automatic test_spurious_done();
    tx_delay = 3;
    spurious_en = 1'b1;
    clear_mon();
    pulse_start();
    wait_dump(3000, "spurious");
    spurious_en = 1'b0;
    check_default_stream("spurious");
  endtask

  task automatic test_start_while_busy();
    tx_delay = 2;
    clear_mon();
    pulse_start();
    repeat (40) @(negedge clk);
    pulse_start();
    repeat (200) @(negedge clk);
    pulse_start();
    wait_dump(3000, "busy_start");
    check_default_stream("busy_start");
    repeat (10) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || bytes_q.size() !== 128) begin
      errors++;
      $display("FAIL busy_start_restart: busy=%b bytes=%0d, expected 0 and 128", busy, bytes_q.size());
    end
  endtask

  task automatic test_reset_mid_dump();
    int n = 0;
    tx_delay = 5;
    clear_mon();
    pulse_start();
    while (bytes_q.size() < 11 && n < 500) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (bytes_q.size() !== 11) begin
      errors++;
      $display("FAIL midreset_reach: got %0d bytes, expected 11", bytes_q.size());
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({rd_addr, tx_data, tx_start, busy, done} !== '0) begin
      errors++;
      $display("FAIL midreset_outputs: addr=%0d data=0x%02h start=%b busy=%b done=%b, expected all 0",
               rd_addr, tx_data, tx_start, busy, done);
    end
    rst = 1'b0;
    repeat (20) @(negedge clk);
    checks++;
    if (bytes_q.size() !== 11 || busy !== 1'b0) begin
      errors++;
      $display("FAIL midreset_quiet: bytes=%0d busy=%b, expected 11 and 0", bytes_q.size(), busy);
    end
    clear_mon();
    pulse_start();
    wait_dump(3000, "midreset_redump");
    check_default_stream("midreset_redump");
  endtask

  task automatic test_back_to_back();
    int exp_gap;
    tx_delay = 1;
    clear_mon();
    pulse_start();
    wait_dump(1000, "b2b");
    checks++;
    if (starts_q.size() !== 128) begin
      errors++;
      $display("FAIL b2b_count: got %0d tx_start pulses, expected 128", starts_q.size());
    end else begin
      checks++;
      if (starts_q[0] - start_cyc !== 3) begin
        errors++;
        $display("FAIL b2b_first_latency: got %0d cycles, expected 3", starts_q[0] - start_cyc);
      end
      for (int i = 1; i < 128; i++) begin
        exp_gap = (i % 4 == 0) ? 4 : 2;
        checks++;
        if (starts_q[i] - starts_q[i - 1] !== exp_gap) begin
          errors++;
          $display("FAIL b2b_gap%0d: got %0d cycles, expected %0d", i, starts_q[i] - starts_q[i - 1], exp_gap);
        end
      end
      checks++;
      if (done_cyc - starts_q[127] !== 2) begin
        errors++;
        $display("FAIL b2b_done_latency: got %0d cycles, expected 2", done_cyc - starts_q[127]);
      end
    end
    checks++;
    if (done_cyc - start_cyc !== 321) begin
      errors++;
      $display("FAIL b2b_total: got %0d cycles, expected 321", done_cyc - start_cyc);
    end
  endtask

  task automatic test_start_held();
    int n = 0;
    bit seen = 1'b0;
    tx_delay = 1;
    clear_mon();
    @(negedge clk);
    start = 1'b1;
    while (!seen && n < 1000) begin
      @(negedge clk);
      n++;
      if (done === 1'b1) seen = 1'b1;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL held_done: no done pulse within 1000 cycles, expected one");
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL held_idle: busy=%b one cycle after done, expected 0", busy);
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b1 || rd_addr !== 5'd0) begin
      errors++;
      $display("FAIL held_restart: busy=%b addr=%0d, expected 1 and 0", busy, rd_addr);
    end
    start = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    for (int n = 0; n < BANK_DEPTH; n++) bank[n] = 32'h03020100 + 32'h04040404 * n;
    test_reset();
    test_full_dump();
    test_deadbeef();
    test_spurious_done();
    test_start_while_busy();
    test_reset_mid_dump();
    test_back_to_back();
    test_start_held();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/reg_dump_unit.md
REG_DUMP_UNIT -- requirements
Module: reg_dump_unit

Interface
REQ-001 The block SHALL have parameter NB_DATA, default 32, register width in bits.
REQ-002 The block SHALL have parameter NB_ADDR, default 5, register-address width.
REQ-003 The block SHALL have parameter BANK_DEPTH, default 32, number of registers dumped.
REQ-004 The block SHALL have parameter NB_BYTE, default 8, width of the serial byte.
REQ-005 The block SHALL have port i_clock, input, 1, clock; all logic on rising edge.
REQ-006 The block SHALL have port i_reset, input, 1, reset, synchronous, active-high.
REQ-007 The block SHALL have port i_start, input, 1, request a full register dump.
REQ-008 The block SHALL have port o_rd_addr, output, NB_ADDR, register-bank read address.
REQ-009 The block SHALL have port i_rd_data, input, NB_DATA, register-bank read data, valid one cycle after o_rd_addr is stable (registered read).
REQ-010 The block SHALL have port o_tx_data, output, NB_BYTE, byte to the UART transmitter.
REQ-011 The block SHALL have port o_tx_start, output, 1, one-cycle pulse launching transmission of o_tx_data.
REQ-012 The block SHALL have port i_tx_done, input, 1, one-cycle pulse from the transmitter when a byte has finished.
REQ-013 The block SHALL have port o_busy, output, 1, high while a dump is in progress.
REQ-014 The block SHALL have port o_done, output, 1, one-cycle pulse when the final byte is acknowledged.

Function
REQ-015 The FSM SHALL have states IDLE, ADDR, LATCH, SEND, WAIT_TX, DONE.
REQ-016 In IDLE, i_start=1 SHALL clear reg_idx and byte_idx to 0 and move to ADDR next cycle.
REQ-017 In ADDR, o_rd_addr SHALL equal reg_idx; the FSM SHALL move to LATCH unconditionally.
REQ-018 In LATCH, i_rd_data SHALL be captured into an NB_DATA shift register, then move to SEND.
REQ-019 o_rd_addr SHALL hold reg_idx in every state except IDLE/DONE, where it SHALL be 0.
REQ-020 In SEND, o_tx_start SHALL be 1 for exactly one cycle with o_tx_data = shift register bits [NB_BYTE-1:0]; next state WAIT_TX.
REQ-021 Bytes SHALL be sent least-significant first; NB_DATA/NB_BYTE (4) bytes per register; 128 bytes per full dump at defaults.
REQ-022 o_tx_data SHALL hold its value from SEND until the next SEND or reset.
REQ-023 In WAIT_TX, the FSM SHALL stay until i_tx_done=1; no timeout.
REQ-024 On i_tx_done with byte_idx < 3: byte_idx increments, shift register shifts right by NB_BYTE, next state SEND.
REQ-025 On i_tx_done with byte_idx = 3 and reg_idx < BANK_DEPTH-1: byte_idx clears, reg_idx increments, next state ADDR.
REQ-026 On i_tx_done with byte_idx = 3 and reg_idx = BANK_DEPTH-1: next state DONE; reg_idx SHALL NOT wrap during the dump.
REQ-027 In DONE, o_done SHALL be 1 for one cycle, then IDLE.
REQ-028 o_busy SHALL be 1 in ADDR, LATCH, SEND, WAIT_TX, DONE; 0 in IDLE.
REQ-029 i_start outside IDLE SHALL be ignored; i_start held high SHALL restart a dump on the cycle after DONE returns to IDLE.
REQ-030 i_tx_done outside WAIT_TX (including the SEND cycle) SHALL be ignored.
REQ-031 Inter-byte gap: minimum one cycle between i_tx_done and the next o_tx_start (SEND), three cycles across a register boundary (ADDR, LATCH, SEND).

Reset
REQ-032 i_reset=1 SHALL force IDLE, reg_idx=0, byte_idx=0, shift register=0, o_rd_addr=0, o_tx_data=0, o_tx_start=0, o_busy=0, o_done=0; it SHALL take priority over all inputs.
REQ-033 Reset mid-dump SHALL abort with no further o_tx_start until a new i_start after reset release.

Verification
REQ-034 Bank r0..r31 = 0x03020100+0x04040404*n, i_start pulse, i_tx_done 5 cycles after each o_tx_start -> 128 bytes 0x00,0x01,...,0x7F in order, one o_done, o_busy falls the cycle after o_done.
REQ-035 r5=0xDEADBEEF -> bytes 20..23 of the stream are 0xEF,0xBE,0xAD,0xDE; o_rd_addr=5 during those bytes.
REQ-036 i_tx_done asserted in the same cycle as o_tx_start and in ADDR -> ignored; byte count and order unchanged.
REQ-037 i_start pulsed while o_busy=1 -> no restart, still exactly 128 bytes and one o_done.
REQ-038 i_reset asserted while waiting on byte 10 -> next cycle all outputs 0, state IDLE; a new i_start dumps from r0 byte 0.
REQ-039 i_tx_done returned 1 cycle after each o_tx_start -> gaps of 2 cycles within a register and 4 across boundaries between successive o_tx_start pulses; total dump length checked against that cycle count.
